// File: rtl/serial_word_adder_pkg.sv
// Shared types and constants for the bit-serial word adder.
package serial_word_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_W = 16;

endpackage

// File: rtl/serial_add_bit_core.sv
// One-bit full adder with its carry flop and a capture of the carry entering the MSB.
module serial_add_bit_core (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic load_carry,
    input  logic en,
    input  logic is_msb,
    input  logic a_bit,
    input  logic b_bit,
    output logic sum_bit,
    output logic carry,
    output logic carry_msb
);

    logic carry_reg;
    logic carry_msb_reg;

    assign sum_bit   = a_bit ^ b_bit ^ carry_reg;
    assign carry     = carry_reg;
    assign carry_msb = carry_msb_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_reg     <= 1'b0;
            carry_msb_reg <= 1'b0;
        end else if (load) begin
            carry_reg     <= load_carry;
            carry_msb_reg <= 1'b0;
        end else if (en) begin
            carry_reg <= (a_bit & b_bit) | (a_bit & carry_reg) | (b_bit & carry_reg);
            // The flop still holds the carry into the MSB while the MSB pair is added.
            if (is_msb) begin
                carry_msb_reg <= carry_reg;
            end
        end
    end

endmodule

// File: rtl/serial_word_adder.sv
// Bit-serial add/subtract: one bit pair per cycle, LSB first, with valid/ready on both sides.
module serial_word_adder
    import serial_word_adder_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         carry_out,
    output logic         overflow
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state_reg;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  sum_reg;
    logic [CW-1:0] cnt_reg;

    logic accept;
    logic run;
    logic is_msb;
    logic sum_bit;
    logic carry;
    logic carry_msb;

    assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign run       = (state_reg == RUN);
    assign is_msb    = (cnt_reg == LAST);
    assign out_valid = (state_reg == DONE);
    assign sum       = sum_reg;
    assign carry_out = carry;
    assign overflow  = carry ^ carry_msb;

    serial_add_bit_core u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept),
        .load_carry (op_sub),
        .en         (run),
        .is_msb     (is_msb),
        .a_bit      (a_reg[0]),
        .b_bit      (b_reg[0]),
        .sum_bit    (sum_bit),
        .carry      (carry),
        .carry_msb  (carry_msb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cnt_reg   <= '0;
        end else if (accept) begin
            // Subtraction is a + ~b with the carry flop preset to 1.
            a_reg     <= a;
            b_reg     <= op_sub ? ~b : b;
            cnt_reg   <= '0;
            state_reg <= RUN;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg <= IDLE;
                end
                RUN: begin
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    sum_reg <= {sum_bit, sum_reg[W-1:1]};
                    cnt_reg <= cnt_reg + CW'(1);
                    if (is_msb) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
